// File: rtl/uart_echo_sched_if.sv
// Purpose: bundles the receiver, RAM and transmitter signals of the echo scheduler.
// Latency: none, wiring only.
// Backpressure: none in the bundle; the scheduler drops bytes when full and paces on tx_done.
// Ports: rx_dv/rx_byte (in), ram_din/ram_write_addr/ram_write_en/ram_read_addr (out),
//        ram_dout (in), tx_dv/tx_byte (out), tx_done (in), count/empty/full/overflow (out).
// master = scheduler side, slave = UART/RAM/environment side.
interface uart_echo_sched_if #(
  parameter int ADDR_W = 9
);
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic [7:0]        ram_din;
  logic [ADDR_W-1:0] ram_write_addr;
  logic              ram_write_en;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [7:0]        ram_dout;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              tx_done;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              overflow;

  modport master (
    input  rx_dv, rx_byte, ram_dout, tx_done,
    output ram_din, ram_write_addr, ram_write_en, ram_read_addr,
           tx_dv, tx_byte, count, empty, full, overflow
  );

  modport slave (
    output rx_dv, rx_byte, ram_dout, tx_done,
    input  ram_din, ram_write_addr, ram_write_en, ram_read_addr,
           tx_dv, tx_byte, count, empty, full, overflow
  );
endinterface

// File: rtl/uart_echo_sched.sv
// Purpose: buffers received UART bytes in an external RAM and replays them to the transmitter in order.
// Latency: write is combinational; first tx_dv appears 3 edges after the buffer turns non-empty.
// Backpressure: bytes arriving while full are dropped (sticky overflow); sending waits for tx_done.
// Ports: ICE_CLK (clock), RST (sync active-high reset), bus (uart_echo_sched_if.master).
// Option: define UART_ECHO_CRLF_EN to follow every transmitted 0x0D with an inserted 0x0A.
module uart_echo_sched #(
  parameter int ADDR_W = 9
) (
  input  logic               ICE_CLK,
  input  logic               RST,
  uart_echo_sched_if.master  bus
);

  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef UART_ECHO_CRLF_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_WAIT, S_LF} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_WAIT} state_t;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              tx_dv_q;
  logic [7:0]        tx_byte_q;
  logic              ovf_q;
  logic              full_w, empty_w;
  logic              wr_fire, send_fire;
`ifdef UART_ECHO_CRLF_EN
  logic              crlf_pend;
  logic              lf_fire;
`endif

  assign full_w  = (cnt == FULL_CNT);
  assign empty_w = (cnt == '0);
  // Writes are suppressed during reset so the RAM never sees a stray byte.
  assign wr_fire = bus.rx_dv & ~full_w & ~RST;

  assign bus.ram_write_en   = wr_fire;
  assign bus.ram_din        = bus.rx_byte;
  assign bus.ram_write_addr = wr_ptr;
  assign bus.ram_read_addr  = rd_ptr;
  assign bus.tx_dv          = tx_dv_q;
  assign bus.tx_byte        = tx_byte_q;
  assign bus.count          = cnt;
  assign bus.empty          = empty_w;
  assign bus.full           = full_w;
  assign bus.overflow       = ovf_q;

  // State register
  always_ff @(posedge ICE_CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty_w) state_nxt = S_FETCH;
      // FETCH only covers the one-cycle RAM read latency.
      S_FETCH: state_nxt = S_SEND;
      S_SEND:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.tx_done) begin
`ifdef UART_ECHO_CRLF_EN
          state_nxt = crlf_pend ? S_LF : S_IDLE;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
`ifdef UART_ECHO_CRLF_EN
      S_LF:    state_nxt = S_WAIT;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: strobes that drive the datapath registers below
  always_comb begin
    send_fire = (state == S_SEND);
`ifdef UART_ECHO_CRLF_EN
    lf_fire   = (state == S_LF);
`endif
  end

  // Datapath: pointers, occupancy, transmit register, overflow flag
  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      ovf_q     <= 1'b0;
`ifdef UART_ECHO_CRLF_EN
      crlf_pend <= 1'b0;
`endif
    end else begin
      tx_dv_q <= 1'b0;
      if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (bus.rx_dv && full_w) ovf_q <= 1'b1;
      if (send_fire) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        tx_byte_q <= bus.ram_dout;
        tx_dv_q   <= 1'b1;
`ifdef UART_ECHO_CRLF_EN
        crlf_pend <= (bus.ram_dout == 8'h0D);
`endif
      end
`ifdef UART_ECHO_CRLF_EN
      // Inserted line feed: no pointer or occupancy movement.
      if (lf_fire) begin
        tx_byte_q <= 8'h0A;
        tx_dv_q   <= 1'b1;
        crlf_pend <= 1'b0;
      end
`endif
      // Simultaneous write and send leave the occupancy unchanged.
      case ({wr_fire, send_fire})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
